// File: rtl/vec_mem_arbiter.sv
// ============================================================================
// Module   : vec_mem_arbiter
// Purpose  : Round-robin arbiter funnelling vector requesters onto a single
//            memory bus, one transaction in flight, with ID-matched responses.
//            Define VEC_MEM_ARBITER_STATS_EN to add grant/wait statistics.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_mem_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int VEC_W   = 512,
    parameter int ID_W    = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ-1:0]       req_is_write_i,
    input  logic [NUM_REQ*VEC_W-1:0] req_addr_i,
    input  logic [NUM_REQ*VEC_W-1:0] req_data_i,
    input  logic [NUM_REQ*ID_W-1:0]  req_id_i,
    output logic                     mem_req_valid_o,
    input  logic                     mem_req_ready_i,
    output logic                     mem_req_is_write_o,
    output logic [VEC_W-1:0]         mem_req_addr_o,
    output logic [VEC_W-1:0]         mem_req_data_o,
    output logic [ID_W-1:0]          mem_req_id_o,
    input  logic                     mem_rsp_valid_i,
    output logic                     mem_rsp_ready_o,
    input  logic [ID_W-1:0]          mem_rsp_id_i,
    input  logic [VEC_W-1:0]         mem_rsp_data_i,
    output logic [NUM_REQ-1:0]       rsp_valid_o,
    input  logic [NUM_REQ-1:0]       rsp_ready_i,
    output logic [VEC_W-1:0]         rsp_data_o,
`ifdef VEC_MEM_ARBITER_STATS_EN
    output logic [NUM_REQ*32-1:0]    stat_grants_o,
    output logic [31:0]              stat_wait_cycles_o,
`endif
    output logic                     err_unexpected_rsp_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        DELIVER  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic                 is_write_q, is_write_d;
    logic [VEC_W-1:0]     addr_q, addr_d;
    logic [VEC_W-1:0]     data_q, data_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [VEC_W-1:0]     rsp_data_q, rsp_data_d;

    logic                 w_arb_found;
    logic [IDX_W-1:0]     w_arb_idx;
    logic [IDX_W-1:0]     w_cand;

    // Scan from rr_ptr upward, wrapping, and take the first valid requester.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        w_cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!w_arb_found && req_valid_i[w_cand]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_cand;
            end
        end
    end

    always_comb begin
        state_d              = state_q;
        rr_ptr_d             = rr_ptr_q;
        grant_d              = grant_q;
        is_write_d           = is_write_q;
        addr_d               = addr_q;
        data_d               = data_q;
        id_d                 = id_q;
        rsp_data_d           = rsp_data_q;
        req_ready_o          = '0;
        mem_req_valid_o      = 1'b0;
        mem_rsp_ready_o      = 1'b0;
        rsp_valid_o          = '0;
        err_unexpected_rsp_o = 1'b0;

        // Outside WAIT_RSP any response is stray: swallow it and flag it.
        if (state_q != WAIT_RSP) begin
            mem_rsp_ready_o      = mem_rsp_valid_i;
            err_unexpected_rsp_o = mem_rsp_valid_i;
        end

        case (state_q)
            IDLE: begin
                if (w_arb_found) begin
                    req_ready_o[w_arb_idx] = 1'b1;
                    grant_d    = w_arb_idx;
                    is_write_d = req_is_write_i[w_arb_idx];
                    addr_d     = req_addr_i[w_arb_idx*VEC_W +: VEC_W];
                    data_d     = req_data_i[w_arb_idx*VEC_W +: VEC_W];
                    id_d       = req_id_i[w_arb_idx*ID_W +: ID_W];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) begin
                    rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    state_d  = is_write_q ? IDLE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                mem_rsp_ready_o = 1'b1;
                if (mem_rsp_valid_i) begin
                    if (mem_rsp_id_i == id_q) begin
                        rsp_data_d = mem_rsp_data_i;
                        state_d    = DELIVER;
                    end else begin
                        err_unexpected_rsp_o = 1'b1;
                    end
                end
            end
            DELIVER: begin
                rsp_valid_o[grant_q] = 1'b1;
                if (rsp_ready_i[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Keep every handshake output quiet while reset is held.
        if (reset_i) begin
            req_ready_o          = '0;
            mem_req_valid_o      = 1'b0;
            mem_rsp_ready_o      = 1'b0;
            rsp_valid_o          = '0;
            err_unexpected_rsp_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            id_q       <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            id_q       <= id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign mem_req_is_write_o = is_write_q;
    assign mem_req_addr_o     = addr_q;
    assign mem_req_data_o     = data_q;
    assign mem_req_id_o       = id_q;
    assign rsp_data_o         = rsp_data_q;

`ifdef VEC_MEM_ARBITER_STATS_EN
    logic [31:0] wait_cnt_q;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat_grant
        logic [31:0] grant_cnt_q;
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                grant_cnt_q <= '0;
            end else if (state_q == IDLE && w_arb_found && w_arb_idx == IDX_W'(g)
                         && grant_cnt_q != 32'hFFFF_FFFF) begin
                grant_cnt_q <= grant_cnt_q + 32'd1;
            end
        end
        assign stat_grants_o[g*32 +: 32] = grant_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wait_cnt_q <= '0;
        end else if (state_q == WAIT_RSP && wait_cnt_q != 32'hFFFF_FFFF) begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
        end
    end

    assign stat_wait_cycles_o = wait_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vec_mem_arbiter.sv
// ============================================================================
// Module   : tb_vec_mem_arbiter
// Purpose  : Directed, table-driven bench for vec_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vec_mem_arbiter;

    localparam int NUM_REQ = 3;
    localparam int VEC_W   = 512;
    localparam int ID_W    = 8;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid, req_ready, req_is_write;
    logic [NUM_REQ*VEC_W-1:0] req_addr, req_data;
    logic [NUM_REQ*ID_W-1:0]  req_id;
    logic                     mem_req_valid, mem_req_ready, mem_req_is_write;
    logic [VEC_W-1:0]         mem_req_addr, mem_req_data;
    logic [ID_W-1:0]          mem_req_id;
    logic                     mem_rsp_valid, mem_rsp_ready;
    logic [ID_W-1:0]          mem_rsp_id;
    logic [VEC_W-1:0]         mem_rsp_data;
    logic [NUM_REQ-1:0]       rsp_valid, rsp_ready;
    logic [VEC_W-1:0]         rsp_data;
    logic                     err;
`ifdef VEC_MEM_ARBITER_STATS_EN
    logic [NUM_REQ*32-1:0]    stat_grants;
    logic [31:0]              stat_wait_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vec_mem_arbiter #(.NUM_REQ(NUM_REQ), .VEC_W(VEC_W), .ID_W(ID_W)) dut (
        .clk_i               (clk),
        .reset_i             (reset),
        .req_valid_i         (req_valid),
        .req_ready_o         (req_ready),
        .req_is_write_i      (req_is_write),
        .req_addr_i          (req_addr),
        .req_data_i          (req_data),
        .req_id_i            (req_id),
        .mem_req_valid_o     (mem_req_valid),
        .mem_req_ready_i     (mem_req_ready),
        .mem_req_is_write_o  (mem_req_is_write),
        .mem_req_addr_o      (mem_req_addr),
        .mem_req_data_o      (mem_req_data),
        .mem_req_id_o        (mem_req_id),
        .mem_rsp_valid_i     (mem_rsp_valid),
        .mem_rsp_ready_o     (mem_rsp_ready),
        .mem_rsp_id_i        (mem_rsp_id),
        .mem_rsp_data_i      (mem_rsp_data),
        .rsp_valid_o         (rsp_valid),
        .rsp_ready_i         (rsp_ready),
        .rsp_data_o          (rsp_data),
`ifdef VEC_MEM_ARBITER_STATS_EN
        .stat_grants_o       (stat_grants),
        .stat_wait_cycles_o  (stat_wait_cycles),
`endif
        .err_unexpected_rsp_o(err)
    );

    function automatic logic [VEC_W-1:0] payload(input logic [7:0] id);
        return {64{id}};
    endfunction

    function automatic logic [7:0] id_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h10;
            2'd1:    return 8'h21;
            default: return 8'h12;
        endcase
    endfunction

    function automatic logic [VEC_W-1:0] exp_addr(input logic [1:0] idx);
        return {16{32'hA000_0000 | 32'(idx)}};
    endfunction

    function automatic logic [VEC_W-1:0] exp_data(input logic [1:0] idx);
        return {16{32'hD000_0000 | 32'(idx)}};
    endfunction

    // Packed control outputs: {req_ready, mem_req_valid, mem_rsp_ready, rsp_valid, err}
    function automatic logic [31:0] ov(input logic [2:0] rr, input logic mv, input logic mr,
                                       input logic [2:0] rv, input logic er);
        return {23'd0, rr, mv, mr, rv, er};
    endfunction

    function automatic logic [31:0] outs();
        return {23'd0, req_ready, mem_req_valid, mem_rsp_ready, rsp_valid, err};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        req_valid     = '0;
        req_is_write  = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_id    = '0;
        mem_rsp_data  = '0;
        rsp_ready     = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  req_valid;
        logic        mem_req_ready;
        logic        rsp_v;
        logic [7:0]  rsp_id;
        logic [31:0] exp_out;
        logic [1:0]  exp_idx;
    } vec_t;

    vec_t tbl[17];

    initial begin
        // Three reads, each answered two cycles after issue: grants 0,1,2,0.
        tbl[0]  = '{3'b111, 1'b1, 1'b0, 8'h00, ov(3'b001, 0, 0, 3'b000, 0), 2'd0};
        tbl[1]  = '{3'b111, 1'b1, 1'b0, 8'h00, ov(3'b000, 1, 0, 3'b000, 0), 2'd0};
        tbl[2]  = '{3'b111, 1'b1, 1'b0, 8'h00, ov(3'b000, 0, 1, 3'b000, 0), 2'd0};
        tbl[3]  = '{3'b111, 1'b1, 1'b1, 8'h10, ov(3'b000, 0, 1, 3'b000, 0), 2'd0};
        tbl[4]  = '{3'b111, 1'b1, 1'b0, 8'h00, ov(3'b000, 0, 0, 3'b001, 0), 2'd0};
        tbl[5]  = '{3'b111, 1'b1, 1'b0, 8'h00, ov(3'b010, 0, 0, 3'b000, 0), 2'd1};
        tbl[6]  = '{3'b111, 1'b1, 1'b0, 8'h00, ov(3'b000, 1, 0, 3'b000, 0), 2'd1};
        tbl[7]  = '{3'b111, 1'b1, 1'b0, 8'h00, ov(3'b000, 0, 1, 3'b000, 0), 2'd1};
        tbl[8]  = '{3'b111, 1'b1, 1'b1, 8'h21, ov(3'b000, 0, 1, 3'b000, 0), 2'd1};
        tbl[9]  = '{3'b111, 1'b1, 1'b0, 8'h00, ov(3'b000, 0, 0, 3'b010, 0), 2'd1};
        tbl[10] = '{3'b111, 1'b1, 1'b0, 8'h00, ov(3'b100, 0, 0, 3'b000, 0), 2'd2};
        tbl[11] = '{3'b111, 1'b1, 1'b0, 8'h00, ov(3'b000, 1, 0, 3'b000, 0), 2'd2};
        tbl[12] = '{3'b111, 1'b1, 1'b0, 8'h00, ov(3'b000, 0, 1, 3'b000, 0), 2'd2};
        tbl[13] = '{3'b111, 1'b1, 1'b1, 8'h12, ov(3'b000, 0, 1, 3'b000, 0), 2'd2};
        tbl[14] = '{3'b111, 1'b1, 1'b0, 8'h00, ov(3'b000, 0, 0, 3'b100, 0), 2'd2};
        tbl[15] = '{3'b111, 1'b1, 1'b0, 8'h00, ov(3'b001, 0, 0, 3'b000, 0), 2'd0};
        tbl[16] = '{3'b111, 1'b1, 1'b0, 8'h00, ov(3'b000, 1, 0, 3'b000, 0), 2'd0};

        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*VEC_W +: VEC_W] = exp_addr(2'(i));
            req_data[i*VEC_W +: VEC_W] = exp_data(2'(i));
            req_id[i*ID_W +: ID_W]     = id_of(2'(i));
        end

        do_reset();
        @(negedge clk);
        chk("reset_ctrl", outs(), 32'd0);
        chk_w("reset_addr", mem_req_addr, '0);
        chk_w("reset_rsp_data", rsp_data, '0);
        chk("reset_id_wr", {23'd0, mem_req_is_write, mem_req_id}, 32'd0);
        tick();

        for (int r = 0; r < 17; r++) begin
            req_valid     = tbl[r].req_valid;
            req_is_write  = 3'b000;
            mem_req_ready = tbl[r].mem_req_ready;
            mem_rsp_valid = tbl[r].rsp_v;
            mem_rsp_id    = tbl[r].rsp_id;
            mem_rsp_data  = payload(tbl[r].rsp_id);
            rsp_ready     = 3'b111;
            @(negedge clk);
            chk($sformatf("tbl%0d_ctrl", r), outs(), tbl[r].exp_out);
            if (tbl[r].exp_out[5]) begin
                chk($sformatf("tbl%0d_id", r), 32'(mem_req_id), 32'(id_of(tbl[r].exp_idx)));
                chk_w($sformatf("tbl%0d_addr", r), mem_req_addr, exp_addr(tbl[r].exp_idx));
            end
            if (tbl[r].exp_out[3:1] != 3'b000)
                chk_w($sformatf("tbl%0d_rdata", r), rsp_data, payload(id_of(tbl[r].exp_idx)));
            tick();
        end
`ifdef VEC_MEM_ARBITER_STATS_EN
        @(negedge clk);
        chk("stat_wait", stat_wait_cycles, 32'd6);
        chk("stat_g0", stat_grants[31:0], 32'd2);
        chk("stat_g1", stat_grants[63:32], 32'd1);
        chk("stat_g2", stat_grants[95:64], 32'd1);
        tick();
`endif

        // Stalled store from requester 2, then an immediate new grant.
        do_reset();
        req_valid    = 3'b100;
        req_is_write = 3'b100;
        @(negedge clk);
        chk("wr_grant", outs(), ov(3'b100, 0, 0, 3'b000, 0));
        tick();
        req_valid    = 3'b000;
        req_is_write = 3'b000;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk($sformatf("wr_stall%0d_ctrl", s), outs(), ov(3'b000, 1, 0, 3'b000, 0));
            chk($sformatf("wr_stall%0d_id", s), {23'd0, mem_req_is_write, mem_req_id}, {23'd0, 1'b1, 8'h12});
            chk_w($sformatf("wr_stall%0d_addr", s), mem_req_addr, exp_addr(2'd2));
            chk_w($sformatf("wr_stall%0d_data", s), mem_req_data, exp_data(2'd2));
            tick();
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("wr_accept", outs(), ov(3'b000, 1, 0, 3'b000, 0));
        tick();
        mem_req_ready = 1'b0;
        req_valid     = 3'b001;
        @(negedge clk);
        chk("wr_b2b_grant", outs(), ov(3'b001, 0, 0, 3'b000, 0));
        tick();

        // Mismatched response ID is dropped before the matching one lands.
        do_reset();
        req_valid = 3'b001;
        @(negedge clk);
        chk("mm_grant", outs(), ov(3'b001, 0, 0, 3'b000, 0));
        tick();
        req_valid     = 3'b000;
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("mm_issue", outs(), ov(3'b000, 1, 0, 3'b000, 0));
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_id    = 8'h11;
        mem_rsp_data  = payload(8'h11);
        @(negedge clk);
        chk("mm_bad_id", outs(), ov(3'b000, 0, 1, 3'b000, 1));
        tick();
        mem_rsp_id   = 8'h10;
        mem_rsp_data = payload(8'h10);
        @(negedge clk);
        chk("mm_good_id", outs(), ov(3'b000, 0, 1, 3'b000, 0));
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = payload(8'hEE);
        @(negedge clk);
        chk("mm_deliver", outs(), ov(3'b000, 0, 0, 3'b001, 0));
        chk_w("mm_rdata", rsp_data, payload(8'h10));
        tick();
        rsp_ready = 3'b001;
        @(negedge clk);
        chk("mm_deliver_hold", outs(), ov(3'b000, 0, 0, 3'b001, 0));
        chk_w("mm_rdata_hold", rsp_data, payload(8'h10));
        tick();
        rsp_ready = 3'b000;
        @(negedge clk);
        chk("mm_idle", outs(), 32'd0);
        tick();

        // Reset in WAIT_RSP: late response is a stray, round robin restarts.
        do_reset();
        req_valid = 3'b010;
        @(negedge clk);
        chk("rst_grant1", outs(), ov(3'b010, 0, 0, 3'b000, 0));
        tick();
        req_valid     = 3'b000;
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("rst_issue", outs(), ov(3'b000, 1, 0, 3'b000, 0));
        tick();
        mem_req_ready = 1'b0;
        @(negedge clk);
        chk("rst_wait", outs(), ov(3'b000, 0, 1, 3'b000, 0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_after_ctrl", outs(), 32'd0);
        chk("rst_after_id", {23'd0, mem_req_is_write, mem_req_id}, 32'd0);
        chk_w("rst_after_addr", mem_req_addr, '0);
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_id    = 8'h21;
        mem_rsp_data  = payload(8'h21);
        @(negedge clk);
        chk("rst_stray_rsp", outs(), ov(3'b000, 0, 1, 3'b000, 1));
        tick();
        mem_rsp_valid = 1'b0;
        req_valid     = 3'b111;
        @(negedge clk);
        chk("rst_next_grant0", outs(), ov(3'b001, 0, 0, 3'b000, 0));
        chk_w("rst_no_rdata", rsp_data, '0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
